// File: rtl/traffic_gen_mc.sv
// Multi-channel traffic generator: per-channel burst configuration, round-robin
// burst arbitration and a single valid/ready output stream with a beat counter.
module traffic_gen_mc #(
  parameter int unsigned           DATA_W    = 8,
  parameter int unsigned           NUM_CH    = 4,
  parameter int unsigned           LEN_W     = 4,
  parameter int unsigned           GAP_W     = 4,
  parameter logic [DATA_W-1:0]     LFSR_TAPS = 8'hB8,
  localparam int unsigned          CH_W      = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_en,
  input  logic [1:0]        cfg_mode,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic              start,
  input  logic              stop,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       tx_count
);

  typedef enum logic {IDLE, SEND} state_e;
  typedef enum logic [1:0] {M_INC, M_LFSR, M_CONST, M_WALK} mode_e;

  state_e            state_q, state_d;
  logic              run_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [15:0]       tx_count_q;
  logic              valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CH_W-1:0]   out_ch_q;
  logic              last_q;
  logic [LEN_W-1:0]  beat_q;

  logic              en_q   [NUM_CH];
  mode_e             mode_q [NUM_CH];
  logic [LEN_W-1:0]  len_q  [NUM_CH];
  logic [GAP_W-1:0]  gapc_q [NUM_CH];
  logic [GAP_W-1:0]  gap_q  [NUM_CH];
  logic [DATA_W-1:0] data_q [NUM_CH];

  logic [NUM_CH-1:0] elig;
  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   cand;
  logic              xfer;
  logic              cfg_ok;
  logic [DATA_W-1:0] seed_ld;
  logic [DATA_W-1:0] data_nxt;
  logic [LEN_W-1:0]  beat_nxt;
  logic [CH_W-1:0]   rr_nxt;

  function automatic logic [DATA_W-1:0] step_data(input mode_e m, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    case (m)
      M_INC:   r = d + 1'b1;
      M_LFSR:  r = (d >> 1) ^ (d[0] ? LFSR_TAPS : '0);
      M_CONST: r = d;
      M_WALK:  r = {d[DATA_W-2:0], d[DATA_W-1]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      elig[i] = run_q && en_q[i] && (gap_q[i] == '0);
  end

  // Round-robin: first eligible channel at or above rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((32'(rr_ptr_q) + i) % NUM_CH);
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    xfer     = ena && valid_q && out_ready;
    cfg_ok   = cfg_we && (32'(cfg_ch) < NUM_CH) && !(state_q == SEND && cfg_ch == out_ch_q);
    seed_ld  = (mode_e'(cfg_mode) == M_LFSR && cfg_seed == '0) ? DATA_W'(1) : cfg_seed;
    data_nxt = step_data(mode_q[out_ch_q], data_q[out_ch_q]);
    beat_nxt = beat_q + 1'b1;
    rr_nxt   = (32'(out_ch_q) == NUM_CH - 1) ? '0 : out_ch_q + 1'b1;
    state_d  = state_q;
    if (ena) begin
      case (state_q)
        IDLE:    if (grant_found) state_d = SEND;
        SEND:    if (xfer && last_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      rr_ptr_q   <= '0;
      tx_count_q <= '0;
      valid_q    <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      last_q     <= 1'b0;
      beat_q     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        en_q[i]   <= 1'b0;
        mode_q[i] <= M_INC;
        len_q[i]  <= '0;
        gapc_q[i] <= '0;
        gap_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (ena) begin
      if (stop)       run_q <= 1'b0;
      else if (start) run_q <= 1'b1;

      for (int unsigned i = 0; i < NUM_CH; i++)
        if (gap_q[i] != '0) gap_q[i] <= gap_q[i] - 1'b1;

      if (cfg_ok) begin
        en_q[cfg_ch]   <= cfg_en;
        mode_q[cfg_ch] <= mode_e'(cfg_mode);
        len_q[cfg_ch]  <= cfg_len;
        gapc_q[cfg_ch] <= cfg_gap;
        data_q[cfg_ch] <= seed_ld;
      end

      // out_data always mirrors the granted channel's data register.
      if (state_q == IDLE) begin
        if (grant_found) begin
          valid_q    <= 1'b1;
          out_ch_q   <= grant_idx;
          out_data_q <= data_q[grant_idx];
          last_q     <= (len_q[grant_idx] == '0);
          beat_q     <= '0;
        end
      end else if (xfer) begin
        tx_count_q       <= tx_count_q + 16'd1;
        data_q[out_ch_q] <= data_nxt;
        if (last_q) begin
          valid_q         <= 1'b0;
          last_q          <= 1'b0;
          gap_q[out_ch_q] <= gapc_q[out_ch_q];
          rr_ptr_q        <= rr_nxt;
        end else begin
          beat_q     <= beat_nxt;
          out_data_q <= data_nxt;
          last_q     <= (beat_nxt == len_q[out_ch_q]);
        end
      end
    end
  end

  assign out_valid = valid_q && ena;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = last_q;
  assign busy      = (state_q == SEND);
  assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_traffic_gen_mc.sv
// Self-checking bench for traffic_gen_mc: directed scenarios plus randomized
// traffic, compared cycle by cycle against a burst-level reference model.
module tb_traffic_gen_mc;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n, ena, cfg_we, cfg_en, start, stop, out_ready;
  logic [1:0] cfg_ch, cfg_mode, out_ch;
  logic [3:0] cfg_len, cfg_gap;
  logic [7:0] cfg_seed, out_data;
  logic       out_valid, out_last, busy;
  logic [15:0] tx_count;

  always #5 clk = ~clk;

  traffic_gen_mc dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
    .cfg_seed(cfg_seed), .start(start), .stop(stop), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .busy(busy), .tx_count(tx_count)
  );

  // Reference model: channel table plus "burst in flight with N beats left".
  bit         m_run, m_act;
  bit         m_en   [N];
  int         m_mode [N];
  int         m_len  [N];
  int         m_gapc [N];
  int         m_gap  [N];
  logic [7:0] m_data [N];
  int         m_ptr, m_ch, m_left, m_tx;

  int checks = 0;
  int errors = 0;
  logic [7:0] beat_q[$];
  int         ch_q[$];

  function automatic logic [7:0] m_next(int mode, logic [7:0] d);
    case (mode)
      0:       return d + 8'd1;
      1:       return (d >> 1) ^ (d[0] ? 8'hB8 : 8'h00);
      2:       return d;
      default: return (d << 1) | (d >> 7);
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_act = 0; m_ptr = 0; m_ch = 0; m_left = 0; m_tx = 0;
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_mode[i] = 0; m_len[i] = 0; m_gapc[i] = 0; m_gap[i] = 0; m_data[i] = 8'h00;
    end
  endtask

  task automatic model_step();
    bit was_act;
    int g;
    if (!rst_n) begin model_reset(); return; end
    if (!ena) return;
    was_act = m_act;
    g = -1;
    if (!m_act)
      for (int i = 0; i < N; i++) begin
        int c = (m_ptr + i) % N;
        if (g < 0 && m_run && m_en[c] && m_gap[c] == 0) g = c;
      end
    for (int i = 0; i < N; i++) if (m_gap[i] > 0) m_gap[i]--;
    if (m_act && out_ready) begin
      m_tx = (m_tx + 1) % 65536;
      m_data[m_ch] = m_next(m_mode[m_ch], m_data[m_ch]);
      m_left--;
      if (m_left == 0) begin
        m_act = 0;
        m_gap[m_ch] = m_gapc[m_ch];
        m_ptr = (m_ch + 1) % N;
      end
    end else if (g >= 0) begin
      m_act = 1; m_ch = g; m_left = m_len[g] + 1;
    end
    if (cfg_we && !(was_act && int'(cfg_ch) == m_ch)) begin
      m_en[cfg_ch] = cfg_en; m_mode[cfg_ch] = cfg_mode; m_len[cfg_ch] = cfg_len;
      m_gapc[cfg_ch] = cfg_gap;
      m_data[cfg_ch] = (cfg_mode == 2'd1 && cfg_seed == 8'h00) ? 8'h01 : cfg_seed;
    end
    if (stop) m_run = 0;
    else if (start) m_run = 1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", 32'(out_valid), 32'(m_act && ena));
    chk("busy", 32'(busy), 32'(m_act));
    chk("tx_count", 32'(tx_count), 32'(m_tx));
    if (m_act && ena) begin
      chk("data", 32'(out_data), 32'(m_data[m_ch]));
      chk("ch", 32'(out_ch), 32'(m_ch));
      chk("last", 32'(out_last), 32'(m_left == 1));
    end
  endtask

  task automatic tick();
    if (out_valid && out_ready && ena) begin
      beat_q.push_back(out_data);
      ch_q.push_back(int'(out_ch));
    end
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"},  32'(out_data), 0);
    chk({tag, "_ch"},    32'(out_ch), 0);
    chk({tag, "_last"},  32'(out_last), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_tx"},    32'(tx_count), 0);
  endtask

  task automatic do_reset();
    ena = 1; rst_n = 0; start = 0; stop = 0; cfg_we = 0; out_ready = 1;
    tick();
    check_zero("rst");
    tick();
    rst_n = 1;
    beat_q.delete();
    ch_q.delete();
  endtask

  task automatic cfg(int ch, int en, int mode, int len, int gap, logic [7:0] seed);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_en = 1'(en); cfg_mode = 2'(mode);
    cfg_len = 4'(len); cfg_gap = 4'(gap); cfg_seed = seed;
    tick();
    cfg_we = 0;
  endtask

  task automatic pulse_start(); start = 1; tick(); start = 0; endtask
  task automatic pulse_stop();  stop  = 1; tick(); stop  = 0; endtask

  logic [7:0] e047 [3] = '{8'h01, 8'hB8, 8'h5C};
  logic [7:0] e_walk [3] = '{8'h80, 8'h01, 8'h02};
  bit rdy_pat [8] = '{1, 0, 0, 1, 1, 1, 0, 1};

  initial begin
    rst_n = 0; ena = 1; cfg_we = 0; cfg_ch = 0; cfg_en = 0; cfg_mode = 0;
    cfg_len = 0; cfg_gap = 0; cfg_seed = 0; start = 0; stop = 0; out_ready = 1;
    model_reset();

    // INC burst, latency and one idle cycle between bursts
    do_reset();
    cfg(0, 1, 0, 3, 0, 8'h10);
    pulse_start();
    tick();
    chk("latency_valid", 32'(out_valid), 1);
    repeat (11) tick();
    chk("inc_count", 32'(beat_q.size() >= 5), 1);
    for (int i = 0; i < 5 && i < beat_q.size(); i++) chk("inc_beat", 32'(beat_q[i]), 32'(8'h10 + i));

    // LFSR with zero seed
    do_reset();
    cfg(1, 1, 1, 2, 0, 8'h00);
    pulse_start();
    repeat (5) tick();
    chk("lfsr_count", 32'(beat_q.size() >= 3), 1);
    for (int i = 0; i < 3 && i < beat_q.size(); i++) chk("lfsr_beat", 32'(beat_q[i]), 32'(e047[i]));

    // Alternating single-beat bursts, disabled channels skipped
    do_reset();
    cfg(0, 1, 2, 0, 0, 8'hAA);
    cfg(2, 1, 2, 0, 0, 8'h55);
    cfg(1, 0, 0, 0, 0, 8'h11);
    cfg(3, 0, 0, 0, 0, 8'h33);
    pulse_start();
    repeat (12) tick();
    chk("rr_count", 32'(ch_q.size() >= 4), 1);
    for (int i = 0; i < ch_q.size(); i++) chk("rr_ch", 32'(ch_q[i]), 32'((i % 2) * 2));

    // WALK wrap from the top bit, pointer wrap from ch3
    do_reset();
    cfg(3, 1, 3, 2, 0, 8'h80);
    pulse_start();
    repeat (6) tick();
    for (int i = 0; i < 3 && i < beat_q.size(); i++) chk("walk_beat", 32'(beat_q[i]), 32'(e_walk[i]));

    // Backpressure with an ignored cfg write to the granted channel
    do_reset();
    cfg(0, 1, 0, 7, 0, 8'h20);
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      out_ready = rdy_pat[i % 8];
      if (i == 4) cfg(0, 1, 2, 0, 0, 8'hFF);
      else tick();
    end
    out_ready = 1;
    chk("stall_count", 32'(beat_q.size() >= 8), 1);
    for (int i = 0; i < 8 && i < beat_q.size(); i++) chk("stall_beat", 32'(beat_q[i]), 32'(8'h20 + i));

    // Stop with simultaneous start mid-burst: burst completes, no new grant
    do_reset();
    cfg(0, 1, 0, 7, 0, 8'h00);
    pulse_start();
    tick();
    tick();
    stop = 1; start = 1;
    tick();
    stop = 0; start = 0;
    repeat (14) tick();
    chk("stop_beats", 32'(beat_q.size()), 8);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_valid", 32'(out_valid), 0);

    // Randomized configurations, backpressure and ena gaps
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < N; c++)
        cfg(c, (c == 0) ? 1 : int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 8'($urandom));
      pulse_start();
      for (int i = 0; i < 150; i++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        ena = ($urandom_range(0, 9) != 0);
        tick();
      end
      ena = 1; out_ready = 1;
      pulse_stop();
      repeat (20) tick();
    end

    // Reset mid-burst aborts it; config must be rewritten
    do_reset();
    cfg(0, 1, 0, 7, 0, 8'h40);
    pulse_start();
    repeat (3) tick();
    rst_n = 0;
    tick();
    check_zero("midrst");
    rst_n = 1;
    pulse_start();
    repeat (10) tick();
    chk("no_traffic", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
